// File: rtl/e_muldiv_unit.sv
// e_muldiv_unit: iterative radix-2 multiply / restoring divide engine for the execute stage.
module e_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mult_en_e,
  input  logic             div_en_e,
  input  logic             unsigned_instr_e,
  input  logic [WIDTH-1:0] srcA_e,
  input  logic [WIDTH-1:0] srcB_e,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_result,
  output logic [WIDTH-1:0] lo_result,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic is_div, is_signed, sign_a, sign_b, dz;
  logic [WIDTH-1:0] acc, mq, opb;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0] msum, dshift, ddiff;
  logic [2*WIDTH-1:0] prod;
  logic start, last, neg;
  logic [WIDTH-1:0] hi_n, lo_n;
  assign start = state == IDLE && (mult_en_e || div_en_e) && !flush;
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state != IDLE;
  assign abs_a = (!unsigned_instr_e && srcA_e[WIDTH-1]) ? -srcA_e : srcA_e;
  assign abs_b = (!unsigned_instr_e && srcB_e[WIDTH-1]) ? -srcB_e : srcB_e;
  assign msum = {1'b0, acc} + (mq[0] ? {1'b0, opb} : '0);
  assign dshift = {acc, mq[WIDTH-1]};
  assign ddiff = dshift - {1'b0, opb};
  assign neg = is_signed && (sign_a ^ sign_b);
  assign prod = neg ? -{acc, mq} : {acc, mq};
  // Remainder follows the dividend's sign, which also makes a signed divide-by-zero return srcA in hi.
  assign hi_n = is_div ? ((is_signed && sign_a) ? -acc : acc) : prod[2*WIDTH-1:WIDTH];
  assign lo_n = is_div ? (dz ? '1 : (neg ? -mq : mq)) : prod[WIDTH-1:0];
  always_comb begin
    state_n = state;
    state_n = flush ? IDLE :
              state == IDLE ? (start ? CALC : IDLE) :
              state == CALC ? (last ? FIX : CALC) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      is_div <= 1'b0;
      is_signed <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      dz <= 1'b0;
      acc <= '0;
      mq <= '0;
      opb <= '0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      hi_result <= '0;
      lo_result <= '0;
    end else begin
      done <= 1'b0;
      div_by_zero <= 1'b0;
      if (start) begin
        is_div <= !mult_en_e;
        is_signed <= !unsigned_instr_e;
        sign_a <= srcA_e[WIDTH-1];
        sign_b <= srcB_e[WIDTH-1];
        dz <= !mult_en_e && srcB_e == '0;
        acc <= '0;
        mq <= mult_en_e ? abs_b : abs_a;
        opb <= mult_en_e ? abs_a : abs_b;
        cnt <= '0;
      end else if (state == CALC && !flush) begin
        cnt <= cnt + 1'b1;
        if (!is_div) begin
          acc <= msum[WIDTH:1];
          mq <= {msum[0], mq[WIDTH-1:1]};
        end else if (!ddiff[WIDTH]) begin
          acc <= ddiff[WIDTH-1:0];
          mq <= {mq[WIDTH-2:0], 1'b1};
        end else begin
          acc <= dshift[WIDTH-1:0];
          mq <= {mq[WIDTH-2:0], 1'b0};
        end
      end else if (state == FIX && !flush) begin
        hi_result <= hi_n;
        lo_result <= lo_n;
        done <= 1'b1;
        div_by_zero <= dz;
      end
    end
  end
endmodule
